keypad_scan_encoder: RTL and testbench
======================================

Name: keypad_scan_encoder

Overview:
- Scans a 4x4 active-low key matrix, debounces presses, and encodes each key into the 8-bit key code consumed on the calculator FSM's `in` input.
- This is the producer end of that interface; the calculator consumes the codes.
- Outputs a level-held code while a key is down and the idle code otherwise, plus a one-cycle new-key strobe.
- Sits between the board keypad pins and `Calculator_fsm`.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven per scan slot; must be >= 2.
- DEBOUNCE, 3: consecutive matching samples required to accept a press or a release; must be >= 1.
- REPEAT_SAMPLES, 8: samples between auto-repeat strobes (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- row_in  in  4  matrix rows, active-low (pulled up; 0 = key closed in the driven column)
- col_out  out  4  column drive, active-low, one-hot-low
- key_code  out  8  encoded key, held while the key is down; 8'h0F when idle
- key_valid  out  1  one-cycle strobe on each accepted press
- key_held  out  1  high while an accepted key remains down

Behaviour:
- Key map, [row][col]:
  - row0: 1 2 3 +
  - row1: 4 5 6 -
  - row2: 7 8 9 *
  - row3: C 0 = /
- Encoding:
  - Digits 0-9: 8'h00-8'h09.
  - Operators: bit7 set, op in [1:0]. + = 8'b1000_0000, - = 8'b1000_0001, * = 8'b1000_0010, / = 8'b1000_0011.
  - Commands: bit6 set. C = 8'b0100_0001, = is 8'b0100_1000.
  - Idle = 8'h0F.
- Reset values: col_out=4'b1110, key_code=8'h0F, key_valid=0, key_held=0, state=SCAN, slot counter=0, column index=0, match counter=0.
- Sampling: row_in is sampled on the last cycle (count SCAN_DIV-1) of each column slot. All outputs are registered.
- SCAN:
  - Columns rotate 0,1,2,3,0 with one slot each.
  - If a sample has any row low, latch {row, col}, set match=1 and go to DEBOUNCE. col_out freezes on that column.
  - If several rows are low in one sample, the lowest row index wins.
  - Keys in different columns: the first column scanned wins.
- DEBOUNCE:
  - On each subsequent sample, if the latched row is low, match++.
  - When match reaches DEBOUNCE: the next cycle, key_code <= encoded key, key_valid=1 for exactly one cycle, key_held=1, go to HOLD.
  - With DEBOUNCE=1, acceptance follows the first detecting sample directly.
  - If the latched row is high on any sample: match=0, return to SCAN, advance to the next column. No strobe; key_code stays 8'h0F.
- HOLD:
  - The column stays frozen.
  - Each sample with the latched row high increments the release counter; a low sample clears it.
  - When the release counter reaches DEBOUNCE: the next cycle, key_code <= 8'h0F, key_held=0, go to SCAN at column 0.
  - Other keys pressed during HOLD are ignored.
- Latency: an accepted press strobes 1 cycle after the DEBOUNCE-th matching sample, i.e. (DEBOUNCE-1)*SCAN_DIV+1 cycles after the first detecting sample.
- Reset mid-operation (any state): all outputs return to reset values on the next clk edge. An in-progress debounce is discarded.
- key_valid is never high in two consecutive cycles, except under the optional feature as specified below.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in HOLD, after every REPEAT_SAMPLES consecutive low samples of the held key, key_valid pulses for one cycle (key_code unchanged). The repeat counter clears on entry to HOLD and on any high sample.
- Undefined: exactly one key_valid per press regardless of hold length; no repeat logic is synthesized.

Test Plan:
1. Reset, idle rows (4'hF) for 100 cycles -> col_out cycles 1110,1101,1011,0111 every 4 cycles; key_code=8'h0F; key_valid never high.
2. Hold '5' (row1 low whenever col_out=4'b1101) from cycle 0 after reset -> samples at cycles 7, 11, 15 match; key_valid high only at cycle 16; key_code=8'h05 from cycle 16; key_held=1.
3. Release '5' after acceptance -> after 3 consecutive high samples, key_code=8'h0F and key_held=0 the next cycle; col_out returns to 4'b1110.
4. Bounce: '*' (row2,col3) low for one sample, then high -> no key_valid; key_code stays 8'h0F; scan resumes at col0. Then hold '*' stably -> key_code=8'b1000_0010 with a single strobe. Then hold '=' stably -> key_code=8'b0100_1000.
5. Rows 1 and 3 both low in col1 ('5' and '0') -> key_code=8'h05. Reset asserted during HOLD -> next cycle key_code=8'h0F, key_held=0, col_out=4'b1110.
6. With KEYPAD_AUTOREPEAT_EN, hold '+' for 30 samples after acceptance -> key_valid repeats every 8 samples (3 extra strobes); key_code=8'b1000_0000 throughout. Without the macro -> exactly 1 strobe.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 active-low matrix, debounces, encodes keys for the calculator FSM.
// Latency: strobe (DEBOUNCE-1)*SCAN_DIV+1 cycles after first detecting sample. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
// Backpressure: none; key_code is level-held and key_valid is a one-cycle strobe the consumer must take.
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_SAMPLES = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE - 1);
  localparam logic [7:0] IDLE_CODE = 8'h0F;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   slot_cnt;
  logic [1:0]      col_idx;
  logic [1:0]      lat_row;
  logic [MW-1:0]   match_cnt;
  logic            slot_last;
  logic            any_low;
  logic            lat_row_low;
  logic [1:0]      hit_row;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SAMPLES - 1);
  logic [RW-1:0]   rep_cnt;
`endif

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = 4'b1111 ^ (4'b0001 << c);
  endfunction

  function automatic logic [7:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [7:0] code;
    case ({r, c})
      4'b00_00: code = 8'h01;
      4'b00_01: code = 8'h02;
      4'b00_10: code = 8'h03;
      4'b00_11: code = 8'b1000_0000;
      4'b01_00: code = 8'h04;
      4'b01_01: code = 8'h05;
      4'b01_10: code = 8'h06;
      4'b01_11: code = 8'b1000_0001;
      4'b10_00: code = 8'h07;
      4'b10_01: code = 8'h08;
      4'b10_10: code = 8'h09;
      4'b10_11: code = 8'b1000_0010;
      4'b11_00: code = 8'b0100_0001;
      4'b11_01: code = 8'h00;
      4'b11_10: code = 8'b0100_1000;
      default:  code = 8'b1000_0011;
    endcase
    return code;
  endfunction

  assign slot_last   = (slot_cnt == SLOT_LAST);
  assign any_low     = ~&row_in;
  assign lat_row_low = ~row_in[lat_row];

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_in[r]) hit_row = 2'(r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      slot_cnt  <= '0;
      col_idx   <= 2'd0;
      lat_row   <= 2'd0;
      match_cnt <= '0;
      col_out   <= 4'b1110;
      key_code  <= IDLE_CODE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      slot_cnt  <= slot_last ? '0 : slot_cnt + 1'b1;
      if (slot_last) begin
        case (state)
          ST_SCAN: begin
            if (any_low) begin
              lat_row <= hit_row;
              if (DEBOUNCE == 1) begin
                key_code  <= encode(hit_row, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match_cnt <= '0;
                state     <= ST_HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                match_cnt <= MW'(1);
                state     <= ST_DEBOUNCE;
              end
            end else begin
              col_idx <= col_idx + 1'b1;
              col_out <= col_drive(col_idx + 1'b1);
            end
          end
          ST_DEBOUNCE: begin
            if (lat_row_low) begin
              if (match_cnt == MATCH_LAST) begin
                key_code  <= encode(lat_row, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match_cnt <= '0;
                state     <= ST_HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              // Bounce: give up on this key and continue scanning after it.
              match_cnt <= '0;
              state     <= ST_SCAN;
              col_idx   <= col_idx + 1'b1;
              col_out   <= col_drive(col_idx + 1'b1);
            end
          end
          ST_HOLD: begin
            if (!lat_row_low) begin
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
              if (match_cnt == MATCH_LAST) begin
                key_code  <= IDLE_CODE;
                key_held  <= 1'b0;
                match_cnt <= '0;
                state     <= ST_SCAN;
                col_idx   <= 2'd0;
                col_out   <= 4'b1110;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rep_cnt == REP_LAST) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
`endif
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: a behavioural key matrix drives row_in from col_out.
module tb_keypad_scan_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = 16'h0000;  // bit r*4+c = key at row r, column c is closed
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobes;

  keypad_scan_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] col_of(input int c);
    return 4'b1111 ^ (4'b0001 << c);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: idle scanning after reset
    do_reset();
    chk("rst_col", {4'h0, col_out}, 8'h0E);
    chk("rst_code", key_code, 8'h0F);
    chk("rst_valid", {7'b0, key_valid}, 8'h00);
    chk("rst_held", {7'b0, key_held}, 8'h00);
    for (int i = 0; i < 100; i++) begin
      chk("idle_col", {4'h0, col_out}, {4'h0, col_of((cyc / 4) % 4)});
      chk("idle_valid", {7'b0, key_valid}, 8'h00);
      tick();
    end
    chk("idle_code", key_code, 8'h0F);

    // 2: hold '5' from cycle 0; samples 7, 11, 15 -> strobe at 16
    do_reset();
    pressed = 16'h0020;
    for (int i = 0; i < 20; i++) begin
      chk("p5_valid", {7'b0, key_valid}, {7'b0, cyc == 16});
      chk("p5_code", key_code, (cyc >= 16) ? 8'h05 : 8'h0F);
      chk("p5_held", {7'b0, key_held}, {7'b0, cyc >= 16});
      chk("p5_col", {4'h0, col_out}, (cyc < 4) ? 8'h0E : 8'h0D);
      tick();
    end

    // 3: release at cycle 20; high samples 23, 27, 31 -> idle at 32
    pressed = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      chk("r5_valid", {7'b0, key_valid}, 8'h00);
      chk("r5_code", key_code, (cyc >= 32) ? 8'h0F : 8'h05);
      chk("r5_held", {7'b0, key_held}, {7'b0, cyc < 32});
      chk("r5_col", {4'h0, col_out}, (cyc >= 32) ? 8'h0E : 8'h0D);
      tick();
    end

    // 4a: '*' closed only for the sample at cycle 15 -> bounce, resume at col0 on cycle 20
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    pressed = 16'h0800;
    for (int i = 0; i < 12; i++) begin
      if (cyc == 16) pressed = 16'h0000;
      chk("bnc_valid", {7'b0, key_valid}, 8'h00);
      chk("bnc_code", key_code, 8'h0F);
      chk("bnc_col", {4'h0, col_out}, (cyc < 20) ? 8'h07 : 8'h0E);
      tick();
    end
    // 4b: hold '*' from cycle 24; samples 35, 39, 43 -> strobe at 44; release at 48 -> idle at 60
    pressed = 16'h0800;
    strobes = 0;
    for (int i = 0; i < 36; i++) begin
      if (cyc == 48) pressed = 16'h0000;
      if (key_valid === 1'b1) strobes++;
      chk("star_valid", {7'b0, key_valid}, {7'b0, cyc == 44});
      chk("star_code", key_code, (cyc >= 44) ? 8'b1000_0010 : 8'h0F);
      tick();
    end
    chk("star_strobes", 8'(strobes), 8'd1);
    chk("star_rel_code", key_code, 8'h0F);
    chk("star_rel_held", {7'b0, key_held}, 8'h00);
    chk("star_rel_col", {4'h0, col_out}, 8'h0E);
    // 4c: hold '=' from cycle 60; samples 71, 75, 79 -> strobe at 80
    pressed = 16'h4000;
    for (int i = 0; i < 21; i++) begin
      chk("eq_valid", {7'b0, key_valid}, {7'b0, cyc == 80});
      chk("eq_code", key_code, (cyc >= 80) ? 8'b0100_1000 : 8'h0F);
      chk("eq_col", {4'h0, col_out}, (cyc < 64) ? 8'h0E : ((cyc < 68) ? 8'h0D : 8'h0B));
      tick();
    end

    // 5a: '5' and '0' together in col1 -> lower row wins
    do_reset();
    pressed = 16'h2020;
    for (int i = 0; i < 20; i++) begin
      chk("dual_valid", {7'b0, key_valid}, {7'b0, cyc == 16});
      chk("dual_code", key_code, (cyc >= 16) ? 8'h05 : 8'h0F);
      tick();
    end
    // 5b: reset while in HOLD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    chk("hrst_code", key_code, 8'h0F);
    chk("hrst_held", {7'b0, key_held}, 8'h00);
    chk("hrst_col", {4'h0, col_out}, 8'h0E);
    chk("hrst_valid", {7'b0, key_valid}, 8'h00);
    // 5c: reset during debounce discards the pending press
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    pressed = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      chk("drst_valid", {7'b0, key_valid}, 8'h00);
      chk("drst_code", key_code, 8'h0F);
      chk("drst_held", {7'b0, key_held}, 8'h00);
      tick();
    end

    // 6: hold '+' (row0 col3); accepted at cycle 24, then 30 more held samples
    do_reset();
    pressed = 16'h0008;
    strobes = 0;
    for (int i = 0; i < 146; i++) begin
      if (key_valid === 1'b1) strobes++;
      chk("plus_code", key_code, (cyc >= 24) ? 8'b1000_0000 : 8'h0F);
      tick();
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("plus_strobes", 8'(strobes), 8'd4);
`else
    chk("plus_strobes", 8'(strobes), 8'd1);
`endif
    chk("plus_held", {7'b0, key_held}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
